pll_lock_seq: RTL and testbench

PLL_LOCK_SEQ -- requirements
Module: pll_lock_seq

---
 rtl/dvi_clk_pkg.sv | 27 ++
 rtl/pll_lock_seq_if.sv | 32 +++
 rtl/sync_2ff.sv | 24 ++
 rtl/pll_lock_seq.sv | 97 +++++++++
 tb/tb_pll_lock_seq.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dvi_clk_pkg.sv
// rtl/dvi_clk_pkg.sv - shared state type, default timing and helpers for the PLL lock sequencer
package dvi_clk_pkg;

    typedef enum logic [1:0] {
        PLL_RST   = 2'd0,
        WAIT_LOCK = 2'd1,
        STABLE    = 2'd2,
        RUN       = 2'd3
    } lock_state_e;

    // Defaults assume a 27 MHz reference: 1 us reset pulse, 100 us stability window, 10 ms relock timeout
    localparam int unsigned DEF_PLL_RST_CYCLES     = 27;
    localparam int unsigned DEF_LOCK_STABLE_CYCLES = 2700;
    localparam int unsigned DEF_RELOCK_TIMEOUT     = 270000;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/pll_lock_seq_if.sv
// rtl/pll_lock_seq_if.sv - PLL lock input and sequencer reset/status outputs
interface pll_lock_seq_if;

    logic       lock;
    logic       pll_reset;
    logic       rst_out;
    logic       ready;
    logic [7:0] lost_cnt;
    logic [7:0] relock_cnt;
    logic [1:0] state;

    modport master (
        input  lock,
        output pll_reset,
        output rst_out,
        output ready,
        output lost_cnt,
        output relock_cnt,
        output state
    );

    modport slave (
        output lock,
        input  pll_reset,
        input  rst_out,
        input  ready,
        input  lost_cnt,
        input  relock_cnt,
        input  state
    );

endinterface

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop single-bit synchronizer, async reset to 0
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pll_lock_seq.sv
// rtl/pll_lock_seq.sv - PLL reset/lock sequencer producing downstream reset and ready from clkin only
module pll_lock_seq
    import dvi_clk_pkg::*;
#(
    parameter int unsigned PLL_RST_CYCLES     = DEF_PLL_RST_CYCLES,
    parameter int unsigned LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES,
    parameter int unsigned RELOCK_TIMEOUT     = DEF_RELOCK_TIMEOUT
) (
    input  logic          clkin,
    input  logic          reset,
    pll_lock_seq_if.master bus
);

    // cnt only ever reaches a parameter minus one, so clog2 of the largest parameter suffices
    localparam int unsigned CW = $clog2(max3(PLL_RST_CYCLES, LOCK_STABLE_CYCLES, RELOCK_TIMEOUT));
    localparam logic [CW-1:0] RST_LAST = CW'(PLL_RST_CYCLES - 1);
    localparam logic [CW-1:0] STB_LAST = CW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(RELOCK_TIMEOUT - 1);

    logic        lock_s;
    lock_state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]  lost_q, lost_d;
    logic [7:0]  relock_q, relock_d;
    logic        pll_reset_q;
    logic        rst_out_q;
    logic        ready_q;

    sync_2ff u_lock_sync (
        .clk (clkin),
        .rst (reset),
        .d_i (bus.lock),
        .q_o (lock_s)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + CW'(1);
        lost_d   = lost_q;
        relock_d = relock_q;
        case (state_q)
            PLL_RST: begin
                if (cnt_q == RST_LAST) state_d = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                // A lock arriving on the timeout cycle takes priority over re-pulsing
                if (lock_s) begin
                    state_d = STABLE;
                end else if (cnt_q == TMO_LAST) begin
                    state_d  = PLL_RST;
                    relock_d = sat_inc8(relock_q);
                end
            end
            STABLE: begin
                if (!lock_s) state_d = WAIT_LOCK;
                else if (cnt_q == STB_LAST) state_d = RUN;
            end
            RUN: begin
                cnt_d = cnt_q;
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                    lost_d  = sat_inc8(lost_q);
                end
            end
            default: state_d = PLL_RST;
        endcase
        if (state_d != state_q) cnt_d = '0;
    end

    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            state_q     <= PLL_RST;
            cnt_q       <= '0;
            lost_q      <= 8'd0;
            relock_q    <= 8'd0;
            pll_reset_q <= 1'b1;
            rst_out_q   <= 1'b1;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            lost_q      <= lost_d;
            relock_q    <= relock_d;
            pll_reset_q <= (state_d == PLL_RST);
            rst_out_q   <= (state_d != RUN);
            ready_q     <= (state_d == RUN);
        end
    end

    assign bus.pll_reset  = pll_reset_q;
    assign bus.rst_out    = rst_out_q;
    assign bus.ready      = ready_q;
    assign bus.lost_cnt   = lost_q;
    assign bus.relock_cnt = relock_q;
    assign bus.state      = state_q;

endmodule

// File: tb/tb_pll_lock_seq.sv
// tb/tb_pll_lock_seq.sv - self-checking bench for pll_lock_seq
module tb_pll_lock_seq;

    localparam int P = 4;
    localparam int L = 8;
    localparam int T = 32;

    logic clkin = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    int   m_mode, m_left, m_lost, m_relock;
    logic m_s1, m_s2;

    pll_lock_seq_if bus ();

    pll_lock_seq #(
        .PLL_RST_CYCLES     (P),
        .LOCK_STABLE_CYCLES (L),
        .RELOCK_TIMEOUT     (T)
    ) dut (
        .clkin (clkin),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clkin = ~clkin;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clkin);
            #1;
        end
    endtask

    task automatic apply_reset(input logic lv);
        reset    = 1'b1;
        bus.lock = lv;
        step(2);
        reset = 1'b0;
    endtask

    task automatic test_reset;
        reset    = 1'b1;
        bus.lock = 1'b1;
        step(3);
        checks++;
        if ({bus.state, bus.pll_reset, bus.rst_out, bus.ready} !== {2'd0, 1'b1, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL reset_outputs: got state=%0d pll_reset=%0b rst_out=%0b ready=%0b, want 0 1 1 0",
                     bus.state, bus.pll_reset, bus.rst_out, bus.ready);
        end
        checks++;
        if ({bus.lost_cnt, bus.relock_cnt} !== 16'd0) begin
            errors++;
            $display("FAIL reset_counters: got lost=%0d relock=%0d, want 0 0", bus.lost_cnt, bus.relock_cnt);
        end
    endtask

    task automatic test_pulse_timeout;
        logic [1:0] es;
        apply_reset(1'b0);
        for (int e = 1; e <= P + T + P; e++) begin
            step(1);
            es = (e < P) ? 2'd0 : (e < P + T) ? 2'd1 : (e < P + T + P) ? 2'd0 : 2'd1;
            checks++;
            if ({bus.state, bus.pll_reset} !== {es, es == 2'd0}) begin
                errors++;
                $display("FAIL pulse_timeout edge %0d: got state=%0d pll_reset=%0b, want %0d %0b",
                         e, bus.state, bus.pll_reset, es, es == 2'd0);
            end
        end
        checks++;
        if (bus.relock_cnt !== 8'd1) begin
            errors++;
            $display("FAIL relock_cnt: got %0d want 1", bus.relock_cnt);
        end
    endtask

    task automatic test_clean_lock;
        apply_reset(1'b0);
        step(P + 2);
        bus.lock = 1'b1;
        for (int k = 1; k <= L + 3; k++) begin
            step(1);
            checks++;
            if ({bus.ready, bus.rst_out} !== {k >= L + 3, k < L + 3}) begin
                errors++;
                $display("FAIL clean_lock edge %0d: got ready=%0b rst_out=%0b, want %0b %0b",
                         k, bus.ready, bus.rst_out, k >= L + 3, k < L + 3);
            end
        end
        checks++;
        if ({bus.state, bus.lost_cnt, bus.relock_cnt} !== {2'd3, 8'd0, 8'd0}) begin
            errors++;
            $display("FAIL clean_lock_status: got state=%0d lost=%0d relock=%0d, want 3 0 0",
                     bus.state, bus.lost_cnt, bus.relock_cnt);
        end
    endtask

    task automatic test_loss_relock;
        bus.lock = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            step(1);
            checks++;
            if ({bus.ready, bus.rst_out} !== {k < 3, k >= 3}) begin
                errors++;
                $display("FAIL loss edge %0d: got ready=%0b rst_out=%0b, want %0b %0b",
                         k, bus.ready, bus.rst_out, k < 3, k >= 3);
            end
        end
        checks++;
        if ({bus.state, bus.lost_cnt} !== {2'd1, 8'd1}) begin
            errors++;
            $display("FAIL loss_status: got state=%0d lost=%0d, want 1 1", bus.state, bus.lost_cnt);
        end
        bus.lock = 1'b1;
        for (int k = 1; k <= L + 3; k++) begin
            step(1);
            checks++;
            if (bus.ready !== (k >= L + 3)) begin
                errors++;
                $display("FAIL relock edge %0d: got ready=%0b want %0b", k, bus.ready, k >= L + 3);
            end
        end
    endtask

    task automatic test_glitch;
        apply_reset(1'b0);
        step(P + 1);
        bus.lock = 1'b1;
        step(5);
        checks++;
        if (bus.state !== 2'd2) begin
            errors++;
            $display("FAIL glitch_pre: got state=%0d want 2", bus.state);
        end
        bus.lock = 1'b0;
        step(1);
        bus.lock = 1'b1;
        for (int k = 7; k <= 7 + L + 2; k++) begin
            step(1);
            if (k == 8) begin
                checks++;
                if (bus.state !== 2'd1) begin
                    errors++;
                    $display("FAIL glitch_wait: got state=%0d want 1", bus.state);
                end
            end
            checks++;
            if (bus.ready !== (k >= 7 + L + 2)) begin
                errors++;
                $display("FAIL glitch edge %0d: got ready=%0b want %0b", k, bus.ready, k >= 7 + L + 2);
            end
        end
    endtask

    task automatic test_tie;
        apply_reset(1'b0);
        step(P + T - 3);
        bus.lock = 1'b1;
        step(3);
        checks++;
        if ({bus.state, bus.pll_reset, bus.relock_cnt} !== {2'd2, 1'b0, 8'd0}) begin
            errors++;
            $display("FAIL tie: got state=%0d pll_reset=%0b relock=%0d, want 2 0 0",
                     bus.state, bus.pll_reset, bus.relock_cnt);
        end
    endtask

    task automatic test_saturation;
        apply_reset(1'b1);
        step(20);
        checks++;
        if (bus.ready !== 1'b1) begin
            errors++;
            $display("FAIL sat_start: got ready=%0b want 1", bus.ready);
        end
        for (int i = 1; i <= 300; i++) begin
            bus.lock = 1'b0;
            step(4);
            checks++;
            if (bus.lost_cnt !== 8'((i > 255) ? 255 : i)) begin
                errors++;
                $display("FAIL saturation loss %0d: got lost=%0d want %0d", i, bus.lost_cnt,
                         (i > 255) ? 255 : i);
            end
            bus.lock = 1'b1;
            step(12);
        end
    endtask

    task automatic test_async_reset;
        checks++;
        if (bus.ready !== 1'b1) begin
            errors++;
            $display("FAIL async_pre: got ready=%0b want 1", bus.ready);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({bus.state, bus.pll_reset, bus.rst_out, bus.ready, bus.lost_cnt, bus.relock_cnt}
                !== {2'd0, 1'b1, 1'b1, 1'b0, 8'd0, 8'd0}) begin
            errors++;
            $display("FAIL async_reset: got state=%0d pll_reset=%0b rst_out=%0b ready=%0b lost=%0d relock=%0d",
                     bus.state, bus.pll_reset, bus.rst_out, bus.ready, bus.lost_cnt, bus.relock_cnt);
        end
    endtask

    // Reference: countdown of cycles left in each phase, lock seen through a two-sample delay
    task automatic model_step(input logic lk);
        logic ls;
        ls   = m_s2;
        m_s2 = m_s1;
        m_s1 = lk;
        case (m_mode)
            0: begin
                m_left--;
                if (m_left == 0) begin m_mode = 1; m_left = T; end
            end
            1: begin
                if (ls) begin
                    m_mode = 2; m_left = L;
                end else begin
                    m_left--;
                    if (m_left == 0) begin
                        m_mode = 0; m_left = P;
                        if (m_relock < 255) m_relock++;
                    end
                end
            end
            2: begin
                if (!ls) begin
                    m_mode = 1; m_left = T;
                end else begin
                    m_left--;
                    if (m_left == 0) m_mode = 3;
                end
            end
            default: begin
                if (!ls) begin
                    m_mode = 1; m_left = T;
                    if (m_lost < 255) m_lost++;
                end
            end
        endcase
    endtask

    task automatic test_random;
        logic        cur;
        int          seg;
        logic [20:0] exp_v, got_v;
        reset    = 1'b1;
        bus.lock = 1'b0;
        step(2);
        m_mode = 0; m_left = P; m_lost = 0; m_relock = 0; m_s1 = 1'b0; m_s2 = 1'b0;
        reset = 1'b0;
        cur = 1'b0;
        seg = 0;
        for (int n = 0; n < 3000; n++) begin
            if (seg == 0) begin
                cur = 1'($urandom_range(0, 1));
                seg = ($urandom_range(0, 3) == 0) ? $urandom_range(20, 50) : $urandom_range(1, 10);
            end
            seg--;
            bus.lock = cur;
            @(posedge clkin);
            model_step(cur);
            #1;
            exp_v = {2'(m_mode), m_mode == 0, m_mode != 3, m_mode == 3, 8'(m_lost), 8'(m_relock)};
            got_v = {bus.state, bus.pll_reset, bus.rst_out, bus.ready, bus.lost_cnt, bus.relock_cnt};
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL random edge %0d: got %h want %h", n, got_v, exp_v);
            end
        end
    endtask

    initial begin
        bus.lock = 1'b0;
        test_reset();
        test_pulse_timeout();
        test_clean_lock();
        test_loss_relock();
        test_glitch();
        test_tie();
        test_saturation();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
